// File: rtl/cxor_pipe.sv
// cxor_pipe: pipelined NBIT-wide XOR/XNOR lane with valid/ready on both sides.
//
// The result is computed combinationally when a beat is accepted and stored in a
// 2-entry output FIFO. o_ready is a flop, so upstream never sees a combinational
// path from i_ready.
//
// Optional feature (define CXOR_POPCNT_EN): a saturating popcount accumulator runs
// over frames delimited by i_last. The running value including each beat is stored
// alongside that beat and presented on o_acc/o_sat. With the macro undefined,
// o_acc and o_sat are tied to 0.
//
// Parameters:
//   NBIT   data width of i_a, i_b, o_data
//   ACC_W  width of the saturating popcount accumulator
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_valid/o_ready       input handshake (o_ready registered)
//   i_a, i_b, i_mode      operands; mode 0 = XOR, 1 = XNOR
//   i_last                last beat of a frame
//   o_valid/i_ready       output handshake (o_valid = FIFO not empty)
//   o_data, o_last        head beat result and frame marker
//   o_acc, o_sat          head beat running popcount and saturation flag
module cxor_pipe #(
  parameter int unsigned NBIT  = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [NBIT-1:0]  i_a,
  input  logic [NBIT-1:0]  i_b,
  input  logic             i_mode,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [NBIT-1:0]  o_data,
  output logic             o_last,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_sat
);

`ifdef CXOR_POPCNT_EN
  typedef struct packed {
    logic [NBIT-1:0]  data;
    logic             last;
    logic [ACC_W-1:0] acc;
    logic             sat;
  } beat_t;
`else
  typedef struct packed {
    logic [NBIT-1:0] data;
    logic            last;
  } beat_t;
`endif

  logic       push, pop;
  logic [1:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  beat_t      slot0_q, slot0_d;  // head
  beat_t      slot1_q, slot1_d;
  beat_t      in_beat;

  logic [NBIT-1:0] result;

  assign push   = i_valid & ready_q;
  assign pop    = o_valid & i_ready;
  assign result = i_mode ? ~(i_a ^ i_b) : (i_a ^ i_b);

`ifdef CXOR_POPCNT_EN
  localparam int unsigned PW = $clog2(NBIT + 1);
  localparam int unsigned SW = ACC_W + PW;

  logic [PW-1:0]    pcnt;
  logic [SW-1:0]    sum;
  logic             over;
  logic [ACC_W-1:0] acc_new;
  logic             sat_new;
  logic [ACC_W-1:0] acc_run_q;
  logic             sat_run_q;

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < NBIT; i++) begin
      pcnt = pcnt + PW'(result[i]);
    end
  end

  // Wide enough that acc_run + popcount never wraps before the saturation compare.
  assign sum     = SW'(acc_run_q) + SW'(pcnt);
  assign over    = sum > SW'({ACC_W{1'b1}});
  assign acc_new = over ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign sat_new = sat_run_q | over;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_run_q <= '0;
      sat_run_q <= 1'b0;
    end else if (push) begin
      acc_run_q <= i_last ? '0 : acc_new;
      sat_run_q <= i_last ? 1'b0 : sat_new;
    end
  end

  always_comb begin
    in_beat      = '0;
    in_beat.data = result;
    in_beat.last = i_last;
    in_beat.acc  = acc_new;
    in_beat.sat  = sat_new;
  end

  assign o_acc = slot0_q.acc;
  assign o_sat = slot0_q.sat;
`else
  always_comb begin
    in_beat      = '0;
    in_beat.data = result;
    in_beat.last = i_last;
  end

  assign o_acc = '0;
  assign o_sat = 1'b0;
`endif

  // Slot 0 is always the head; slot 1 only holds a beat when cnt = 2.
  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) slot0_d = in_beat;
        else               slot1_d = in_beat;
      end
      2'b01: begin
        cnt_d   = cnt_q - 2'd1;
        slot0_d = slot1_q;
      end
      2'b11: begin
        // Only reachable with cnt = 1: the new beat replaces the popped head.
        slot0_d = in_beat;
      end
      default: ;
    endcase
    ready_d = cnt_d < 2'd2;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = cnt_q != 2'd0;
  assign o_data  = slot0_q.data;
  assign o_last  = slot0_q.last;

endmodule

// File: tb/tb_cxor_pipe.sv
// Scoreboard bench for cxor_pipe: the driver pushes expected beats computed by a
// frame-level popcount model; a monitor pops and compares on every output transfer.
// A second instance with ACC_W=4 exercises accumulator saturation.
module tb_cxor_pipe;

`ifdef CXOR_POPCNT_EN
  localparam bit POP = 1'b1;
`else
  localparam bit POP = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [15:0] acc;
    logic        sat;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid, i_mode, i_last, i_ready;
  logic [7:0]  i_a, i_b;
  logic        o_ready, o_valid, o_last, o_sat;
  logic [7:0]  o_data;
  logic [15:0] o_acc;

  logic        s_valid, s_mode, s_last;
  logic [7:0]  s_a, s_b;
  logic        s_ready, s_ovalid, s_olast, s_sat;
  logic [7:0]  s_data;
  logic [3:0]  s_acc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;
  exp_t q[$];

  // Frame-level reference state
  int unsigned m_acc = 0;
  bit          m_sat = 1'b0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  cxor_pipe #(.NBIT(8), .ACC_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_mode(i_mode), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_acc(o_acc), .o_sat(o_sat)
  );

  cxor_pipe #(.NBIT(8), .ACC_W(4)) dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(s_valid), .o_ready(s_ready),
    .i_a(s_a), .i_b(s_b), .i_mode(s_mode), .i_last(s_last),
    .o_valid(s_ovalid), .i_ready(1'b1), .o_data(s_data), .o_last(s_olast),
    .o_acc(s_acc), .o_sat(s_sat)
  );

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic void model_push(input logic [7:0] a, input logic [7:0] b,
                                     input logic mode, input logic last);
    exp_t        e;
    int unsigned s, lim;
    lim    = 16'hFFFF;
    e.data = mode ? ~(a ^ b) : (a ^ b);
    e.last = last;
    s      = m_acc + $countones(e.data);
    e.acc  = POP ? 16'((s > lim) ? lim : s) : 16'd0;
    e.sat  = POP ? (m_sat | (s > lim)) : 1'b0;
    q.push_back(e);
    m_acc = last ? 0 : e.acc;
    m_sat = last ? 1'b0 : e.sat;
  endfunction

  // Offer one beat; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic mode, input logic last);
    bit done = 1'b0;
    int waited = 0;
    i_valid = 1'b1; i_a = a; i_b = b; i_mode = mode; i_last = last;
    while (!done && waited < 100) begin
      @(negedge i_clk);
      if (o_ready) begin
        model_push(a, b, mode, last);
        n_acc++;
        done = 1'b1;
      end
      @(posedge i_clk); #1;
      waited++;
    end
    if (!done) check("accept_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got data=%0h with no beat pending", o_data);
      end else begin
        e = q.pop_front();
        if (o_data !== e.data || o_last !== e.last || o_acc !== e.acc || o_sat !== e.sat) begin
          bad++;
          $display("FAIL beat: got data=%0h last=%0b acc=%0d sat=%0b expected %0h %0b %0d %0b",
                   o_data, o_last, o_acc, o_sat, e.data, e.last, e.acc, e.sat);
        end
      end
    end
  end

  task automatic send_s(input logic last, input int exp_acc, input bit exp_sat);
    s_valid = 1'b1; s_a = 8'hFF; s_b = 8'hFF; s_mode = 1'b1; s_last = last;
    @(negedge i_clk);
    check("sat_ready", s_ready, 1);
    @(posedge i_clk); #1;
    s_valid = 1'b0;
    check("sat_valid", s_ovalid, 1);
    check("sat_acc", s_acc, exp_acc);
    check("sat_flag", s_sat, exp_sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_mode = 1'b0; i_last = 1'b0;
    i_ready = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_mode = 1'b0; s_last = 1'b0;
    #1;
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_acc", o_acc, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("ready_after_rst", o_ready, 1);

    // Mode check with one-cycle latency
    send(8'hA5, 8'h0F, 1'b0, 1'b0);
    check("xor_valid", o_valid, 1);
    check("xor_data", o_data, 8'hAA);
    send(8'hA5, 8'h0F, 1'b1, 1'b1);
    check("xnor_data", o_data, 8'h55);
    drain();

    // Backpressure: 3 beats offered with i_ready low
    i_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b1, 1'b0);
        send(8'h55, 8'h66, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(negedge i_clk);
        check("bp_ready_low", o_ready, 0);
        check("bp_accepted", n_acc, 2);
        repeat (3) @(negedge i_clk);
        check("bp_held", n_acc, 2);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // Streaming 16 random beats, expect one accept per clock
    begin
      int start;
      start = cyc;
      for (int i = 0; i < 16; i++) begin
        send(8'($urandom), 8'($urandom), 1'($urandom), (i == 15));
      end
      check("stream_cycles", cyc - start, 16);
    end
    drain();

    // Popcount frame, then first beat of the next frame left open
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b1);
    send(8'h00, 8'h01, 1'b1, 1'b0);
    drain();

    // Reset with two beats queued and a partial frame
    i_ready = 1'b0;
    send(8'h0F, 8'h00, 1'b0, 1'b0);
    send(8'hF0, 8'h00, 1'b0, 1'b0);
    i_rst = 1'b1;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 0);
    check("midrst_acc", o_acc, 0);
    q.delete();
    m_acc = 0; m_sat = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("postrst_ready_low", o_ready, 0);
    @(posedge i_clk); #1;
    check("postrst_ready", o_ready, 1);
    i_ready = 1'b1;
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    send(8'h3C, 8'h00, 1'b1, 1'b1);
    drain();

    // Saturation on the narrow accumulator
    send_s(1'b0, POP ? 8 : 0, 1'b0);
    send_s(1'b0, POP ? 15 : 0, POP);
    send_s(1'b1, POP ? 15 : 0, POP);
    send_s(1'b0, POP ? 8 : 0, 1'b0);

    repeat (3) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
